// File: rtl/pow2_window_accumulator.sv
// Collects 2^n unsigned samples into a saturating sum and hands the window sum,
// its n and a saturation flag to the downstream divider over valid/ready.
module pow2_window_accumulator #(
    parameter int DATA_W = 8,
    parameter int N_W    = 4,
    parameter int MAX_N  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [N_W-1:0]    n_cfg,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_sum,
    output logic [N_W-1:0]    m_n,
    output logic              m_sat
);

    // One extra bit so a full window of 2^MAX_N samples is representable.
    localparam int CNT_W = MAX_N + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [N_W-1:0]    win_n_q, win_n_d;
    logic              sat_q, sat_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_sum_q, m_sum_d;
    logic [N_W-1:0]    m_n_q, m_n_d;
    logic              m_sat_q, m_sat_d;

    logic              accept;
    logic [N_W-1:0]    n_eff;
    logic [DATA_W:0]   sum_wide;
    logic              sat_upd;
    logic [DATA_W-1:0] acc_upd;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  window_len;

    assign s_ready = (state_q != HOLD);
    assign accept  = s_valid && s_ready;

    assign n_eff      = (n_cfg > N_W'(MAX_N)) ? N_W'(MAX_N) : n_cfg;
    assign sum_wide   = {1'b0, acc_q} + {1'b0, s_data};
    assign sat_upd    = sat_q | sum_wide[DATA_W];
    assign acc_upd    = sat_upd ? {DATA_W{1'b1}} : sum_wide[DATA_W-1:0];
    assign count_inc  = count_q + CNT_W'(1);
    assign window_len = CNT_W'(1) << win_n_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        win_n_d   = win_n_q;
        sat_d     = sat_q;
        m_valid_d = m_valid_q;
        m_sum_d   = m_sum_q;
        m_n_d     = m_n_q;
        m_sat_d   = m_sat_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    win_n_d = n_eff;
                    acc_d   = s_data;
                    count_d = CNT_W'(1);
                    sat_d   = 1'b0;
                    if (n_eff == '0) begin
                        state_d   = HOLD;
                        m_valid_d = 1'b1;
                        m_sum_d   = s_data;
                        m_n_d     = n_eff;
                        m_sat_d   = 1'b0;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d   = acc_upd;
                    sat_d   = sat_upd;
                    count_d = count_inc;
                    if (count_inc == window_len) begin
                        state_d   = HOLD;
                        m_valid_d = 1'b1;
                        m_sum_d   = acc_upd;
                        m_n_d     = win_n_q;
                        m_sat_d   = sat_upd;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                    acc_d     = '0;
                    count_d   = '0;
                    sat_d     = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        endcase

        // A flush wins over everything; the result registers keep their last value.
        if (clear) begin
            state_d   = IDLE;
            acc_d     = '0;
            count_d   = '0;
            sat_d     = 1'b0;
            m_valid_d = 1'b0;
            m_sum_d   = m_sum_q;
            m_n_d     = m_n_q;
            m_sat_d   = m_sat_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            win_n_q   <= '0;
            sat_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_sum_q   <= '0;
            m_n_q     <= '0;
            m_sat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            win_n_q   <= win_n_d;
            sat_q     <= sat_d;
            m_valid_q <= m_valid_d;
            m_sum_q   <= m_sum_d;
            m_n_q     <= m_n_d;
            m_sat_q   <= m_sat_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_sum   = m_sum_q;
    assign m_n     = m_n_q;
    assign m_sat   = m_sat_q;

    a_valid_tracks_hold : assert property (@(posedge clk) disable iff (rst)
        m_valid_q == (state_q == HOLD));

    a_result_stable : assert property (@(posedge clk) disable iff (rst)
        (m_valid && !m_ready && !clear) |=>
            (m_valid && $stable(m_sum) && $stable(m_n) && $stable(m_sat)));

    a_count_bounded : assert property (@(posedge clk) disable iff (rst)
        (state_q == ACC) |-> (count_q < window_len));

endmodule

// File: tb/tb_pow2_window_accumulator.sv
// Randomized and directed bench for pow2_window_accumulator: a window-level
// reference model feeds a result queue that an independent monitor drains.
module tb_pow2_window_accumulator;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [3:0] n_cfg;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_sum;
    logic [3:0] m_n;
    logic       m_sat;

    typedef struct {
        int sum;
        int n;
        bit sat;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    bit mdl_hold  = 1'b0;
    int mdl_cnt   = 0;
    int mdl_wn    = 0;
    int mdl_total = 0;

    pow2_window_accumulator #(
        .DATA_W(8),
        .N_W   (4),
        .MAX_N (7)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .n_cfg  (n_cfg),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_sum  (m_sum),
        .m_n    (m_n),
        .m_sat  (m_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("s_ready", s_ready, !mdl_hold);
        check("m_valid", m_valid, mdl_hold);
    endtask

    // A finished window is the plain sum of its samples, capped at 255.
    task automatic push_window();
        exp_t e;
        e.sum = (mdl_total > 255) ? 255 : mdl_total;
        e.n   = mdl_wn;
        e.sat = (mdl_total > 255);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check.
    task automatic applyStimulus(input bit v, input int d, input int n,
                                 input bit mr, input bit clr, output bit acc);
        s_valid = v;
        s_data  = 8'(d);
        n_cfg   = 4'(n);
        m_ready = mr;
        clear   = clr;
        acc     = 1'b0;
        @(posedge clk);
        if (clr) begin
            if (mdl_hold && exp_q.size() > 0) exp_q.delete(0);
            mdl_hold  = 1'b0;
            mdl_cnt   = 0;
            mdl_total = 0;
        end else if (mdl_hold) begin
            if (mr) mdl_hold = 1'b0;
        end else if (v) begin
            acc = 1'b1;
            if (mdl_cnt == 0) begin
                mdl_wn    = (n > 7) ? 7 : n;
                mdl_total = 0;
            end
            mdl_total += d;
            mdl_cnt++;
            if (mdl_cnt == (1 << mdl_wn)) begin
                push_window();
                mdl_hold = 1'b1;
                mdl_cnt  = 0;
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic send_sample(input int d, input int n, input bit mr);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 300) begin
            applyStimulus(1'b1, d, n, mr, 1'b0, acc);
            tries++;
        end
        if (!acc) check("send_accepted", acc, 1);
    endtask

    task automatic idle_cycles(input int count, input bit mr);
        bit acc;
        for (int i = 0; i < count; i++) applyStimulus(1'b0, 0, 0, mr, 1'b0, acc);
    endtask

    // Monitor: compares every presented result against the queue head and
    // retires it on a real handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && m_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("result_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q[0];
                    check("m_sum", m_sum, e.sum);
                    check("m_n", m_n, e.n);
                    check("m_sat", m_sat, e.sat);
                    if (m_ready && !clear) exp_q.delete(0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        rst     = 1'b1;
        clear   = 1'b0;
        n_cfg   = '0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_m_valid", m_valid, 0);
        check("reset_s_ready", s_ready, 1);
        check("reset_m_sum", m_sum, 0);
        check("reset_m_n", m_n, 0);
        check("reset_m_sat", m_sat, 0);
        rst = 1'b0;

        $display("[TB] basic window");
        send_sample(10, 2, 1'b1);
        send_sample(20, 2, 1'b1);
        send_sample(30, 2, 1'b1);
        send_sample(41, 2, 1'b1);
        idle_cycles(2, 1'b1);

        $display("[TB] single-sample window");
        send_sample(200, 0, 1'b1);
        idle_cycles(2, 1'b1);

        $display("[TB] saturation and sat isolation");
        send_sample(200, 1, 1'b1);
        send_sample(100, 1, 1'b1);
        send_sample(3, 1, 1'b1);
        send_sample(4, 1, 1'b1);
        idle_cycles(2, 1'b1);

        $display("[TB] backpressure");
        send_sample(5, 1, 1'b0);
        send_sample(6, 1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 99, 1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 99, 1, 1'b1, 1'b0, acc);
        check("bp_handshake_no_accept", acc, 0);
        applyStimulus(1'b1, 99, 1, 1'b1, 1'b0, acc);
        check("bp_accept_after_bubble", acc, 1);
        send_sample(1, 1, 1'b1);
        idle_cycles(2, 1'b1);

        $display("[TB] config latching and clamping");
        send_sample(1, 2, 1'b1);
        send_sample(2, 1, 1'b1);
        send_sample(3, 1, 1'b1);
        send_sample(4, 1, 1'b1);
        idle_cycles(2, 1'b1);
        for (int i = 0; i < 128; i++) send_sample(1, 12, 1'b1);
        idle_cycles(2, 1'b1);

        $display("[TB] clear mid-window");
        send_sample(7, 2, 1'b1);
        send_sample(8, 2, 1'b1);
        applyStimulus(1'b0, 0, 2, 1'b1, 1'b1, acc);
        for (int i = 0; i < 4; i++) send_sample(1, 2, 1'b1);
        idle_cycles(2, 1'b1);

        $display("[TB] async reset in hold");
        send_sample(50, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, acc);
        rst = 1'b1;
        #1;
        check("rst_async_m_valid", m_valid, 0);
        check("rst_async_s_ready", s_ready, 1);
        check("rst_async_m_sum", m_sum, 0);
        mdl_hold  = 1'b0;
        mdl_cnt   = 0;
        mdl_total = 0;
        exp_q.delete();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, acc);
        rst = 1'b0;
        idle_cycles(1, 1'b1);

        $display("[TB] clear coincident with handshake");
        send_sample(60, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, acc);
        idle_cycles(2, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit mr;
            bit clr;
            int d;
            int n;
            v   = ($urandom % 4) != 0;
            d   = ($urandom % 2 == 0) ? $urandom_range(128, 255) : $urandom_range(0, 63);
            n   = ($urandom % 8 == 0) ? $urandom_range(8, 15) : $urandom_range(0, 3);
            mr  = ($urandom % 3) != 0;
            clr = ($urandom % 40) == 0;
            applyStimulus(v, d, n, mr, clr, acc);
        end
        idle_cycles(3, 1'b1);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
